// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run-flag controller.
// Contents:
//   BCD_W     - width of one BCD digit
//   jkCmd_e   - {J,K} command encoding for the run-flag JK flip-flop
//   state_e   - controller FSM states
//   bcdInc    - increments a 4-digit BCD value, reports the 99.99 -> 00.00 wrap
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,   // reserved, never issued by the controller
    JK_TOGGLE = 2'b11
  } jkCmd_e;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_CHK   = 3'd1,
    ST_IDLE  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  // Returns {wrap, next}: next = value + 1 hundredth with decimal carries,
  // wrap = 1 when the carry ripples out of the tens-of-seconds digit.
  function automatic logic [16:0] bcdInc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[i*BCD_W +: BCD_W] == 4'd9) begin
          result[i*BCD_W +: BCD_W] = 4'd0;
          carry = 1'b1;
        end else begin
          result[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        result[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W];
      end
    end
    return {carry, result};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, press pulse.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset (level returns to released)
//   btnRaw     - asynchronous raw button level
//   pressPulse - 1-cycle pulse when the debounced level goes 0 -> 1
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic pressPulse
);

  localparam int CNT_W = 16;

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             differ_s;
  logic             settle_s;

  // cnt_r counts consecutive synchronized samples that disagree with the
  // accepted level; the Nth such sample flips the level.
  assign differ_s = (sync2_r != level_r);
  assign settle_s = differ_s && (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Synchronizer, debounce counter, accepted level and press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      level_r    <= 1'b0;
      cnt_r      <= '0;
      pressPulse <= 1'b0;
    end else begin
      sync1_r    <= btnRaw;
      sync2_r    <= sync1_r;
      pressPulse <= settle_s && sync2_r;
      if (settle_s) begin
        level_r <= sync2_r;
        cnt_r   <= '0;
      end else if (differ_s) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_jk_ctrl.sv
// Stopwatch run-flag controller. Drives J/K of the external run-flag JK
// flip-flop with single-cycle commands, checks Q one cycle after each
// command, and runs an SS.cc BCD counter while running.
// Ports:
//   CP       - clock, rising edge
//   RST      - synchronous active-high reset
//   BTN_SS   - raw start/stop button
//   BTN_CLR  - raw clear button
//   TICK     - 100 Hz single-cycle strobe
//   Q        - JK flip-flop output, fed back
//   J, K     - JK command outputs (registered)
//   RUNNING  - high in the RUN state
//   ERR      - sticky flag: Q did not follow a command
//   DIGITS   - BCD time {tens s, s, tenths, hundredths}
//   WRAP     - 1-cycle pulse on 99.99 -> 00.00
module stopwatch_jk_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        CP,
  input  logic        RST,
  input  logic        BTN_SS,
  input  logic        BTN_CLR,
  input  logic        TICK,
  input  logic        Q,
  output logic        J,
  output logic        K,
  output logic        RUNNING,
  output logic        ERR,
  output logic [15:0] DIGITS,
  output logic        WRAP
);

  state_e      state_r;
  state_e      target_r;     // state to enter if the check passes
  logic        expQ_r;       // Q value the pending check expects
  logic        cmdWait_r;    // 1 during the command cycle, 0 in the sample cycle
  logic        ssPulse_s;
  logic        clrPulse_s;
  logic [16:0] incr_s;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) ssDebounce (
    .clk        (CP),
    .rst        (RST),
    .btnRaw     (BTN_SS),
    .pressPulse (ssPulse_s)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) clrDebounce (
    .clk        (CP),
    .rst        (RST),
    .btnRaw     (BTN_CLR),
    .pressPulse (clrPulse_s)
  );

  assign incr_s = bcdInc(DIGITS);

  // Controller FSM with registered J/K, status flags and BCD counter.
  // CHK spans two cycles: the command cycle (cmdWait_r=1), in which the
  // flip-flop takes the command, then the cycle in which Q is compared.
  always_ff @(posedge CP) begin
    if (RST) begin
      state_r   <= ST_INIT;
      target_r  <= ST_IDLE;
      expQ_r    <= 1'b0;
      cmdWait_r <= 1'b0;
      {J, K}    <= JK_RESET;
      RUNNING   <= 1'b0;
      ERR       <= 1'b0;
      DIGITS    <= 16'h0000;
      WRAP      <= 1'b0;
    end else begin
      {J, K} <= JK_HOLD;
      WRAP   <= 1'b0;
      case (state_r)
        ST_INIT: begin
          {J, K}    <= JK_RESET;
          expQ_r    <= 1'b0;
          target_r  <= ST_IDLE;
          cmdWait_r <= 1'b1;
          state_r   <= ST_CHK;
        end
        ST_CHK: begin
          if (cmdWait_r) begin
            cmdWait_r <= 1'b0;
          end else if (Q == expQ_r) begin
            state_r <= target_r;
            RUNNING <= (target_r == ST_RUN);
          end else begin
            state_r <= ST_FAULT;
            ERR     <= 1'b1;
            RUNNING <= 1'b0;
          end
        end
        ST_IDLE, ST_RUN, ST_PAUSE: begin
          // Clear wins over start/stop; its cycle also swallows any TICK.
          if (clrPulse_s) begin
            {J, K}    <= JK_RESET;
            DIGITS    <= 16'h0000;
            expQ_r    <= 1'b0;
            target_r  <= ST_IDLE;
            cmdWait_r <= 1'b1;
            state_r   <= ST_CHK;
            RUNNING   <= 1'b0;
          end else begin
            if ((state_r == ST_RUN) && TICK && Q) begin
              DIGITS <= incr_s[15:0];
              WRAP   <= incr_s[16];
            end
            if (ssPulse_s) begin
              {J, K}    <= JK_TOGGLE;
              expQ_r    <= (state_r != ST_RUN);
              target_r  <= (state_r == ST_RUN) ? ST_PAUSE : ST_RUN;
              cmdWait_r <= 1'b1;
              state_r   <= ST_CHK;
              RUNNING   <= 1'b0;
            end
          end
        end
        ST_FAULT: begin
          RUNNING <= 1'b0;
        end
        default: begin
          state_r <= ST_FAULT;
          ERR     <= 1'b1;
          RUNNING <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_jk_ctrl.sv
// Self-checking bench for stopwatch_jk_ctrl with a behavioural JK
// flip-flop attached to J/K/Q and a cycle-level reference model.
module tb_stopwatch_jk_ctrl;

  localparam int N = 4;

  logic        CP = 1'b0;
  logic        RST = 1'b1;
  logic        BTN_SS = 1'b0;
  logic        BTN_CLR = 1'b0;
  logic        TICK = 1'b0;
  logic        Q = 1'b0;
  logic        J, K, RUNNING, ERR, WRAP;
  logic [15:0] DIGITS;

  stopwatch_jk_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .CP(CP), .RST(RST), .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR), .TICK(TICK),
    .Q(Q), .J(J), .K(K), .RUNNING(RUNNING), .ERR(ERR), .DIGITS(DIGITS),
    .WRAP(WRAP)
  );

  always #5 CP = ~CP;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural JK flip-flop (the plant), optionally stuck at 0.
  logic stuck = 1'b0;
  always @(posedge CP) begin
    if (stuck) Q <= 1'b0;
    else begin
      case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

  // ---------------- reference model ----------------
  localparam int M_INIT = 0, M_IDLE = 1, M_RUN = 2, M_PAUSE = 3, M_FAULT = 4, M_BUSY = 5;
  int     mMode = M_INIT;
  int     mPhase = 0;
  int     mNext = M_IDLE;
  logic   mExpQ = 1'b0;
  int     mCount = 0;
  logic   eJ = 1'b0, eK = 1'b1, eRun = 1'b0, eErr = 1'b0, eWrap = 1'b0;
  logic   ssPend = 1'b0, clrPend = 1'b0;
  logic [1:0]   ssPipe = '0, clrPipe = '0;
  logic         ssLvl = 1'b0, clrLvl = 1'b0;
  logic [N-1:0] ssWin = '0, clrWin = '0;
  bit     modelLive = 0;
  int     cyc = 0;

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic issue(input logic [1:0] jk, input logic expq, input int nxt);
    {eJ, eK} = jk;
    mExpQ = expq;
    mNext = nxt;
    mPhase = 1;
    mMode = M_BUSY;
  endtask

  always @(posedge CP) begin
    cyc++;
    if (RST) begin
      mMode = M_INIT; mCount = 0;
      eJ = 1'b0; eK = 1'b1; eRun = 1'b0; eErr = 1'b0; eWrap = 1'b0;
      ssPend = 1'b0; clrPend = 1'b0; ssPipe = '0; clrPipe = '0;
      ssLvl = 1'b0; clrLvl = 1'b0; ssWin = '0; clrWin = '0;
    end else begin
      eJ = 1'b0; eK = 1'b0; eWrap = 1'b0;
      case (mMode)
        M_INIT: issue(2'b01, 1'b0, M_IDLE);
        M_BUSY: begin
          if (mPhase == 1) mPhase = 2;
          else if (Q == mExpQ) mMode = mNext;
          else begin mMode = M_FAULT; eErr = 1'b1; end
        end
        M_IDLE, M_RUN, M_PAUSE: begin
          if (clrPend) begin
            issue(2'b01, 1'b0, M_IDLE);
            mCount = 0;
          end else begin
            if (mMode == M_RUN && TICK && Q) begin
              mCount = (mCount + 1) % 10000;
              eWrap = (mCount == 0);
            end
            if (ssPend) issue(2'b11, mMode != M_RUN, (mMode == M_RUN) ? M_PAUSE : M_RUN);
          end
        end
        default: ;
      endcase
      eRun = (mMode == M_RUN);
      // Debounce: level flips once the last N synchronized samples all
      // disagree with it; a 0->1 flip is a press seen on the next edge.
      ssWin  = {ssWin[N-2:0], ssPipe[1]};
      ssPipe = {ssPipe[0], BTN_SS};
      ssPend = 1'b0;
      if (ssWin == {N{~ssLvl}}) begin ssLvl = ~ssLvl; ssPend = ssLvl; end
      clrWin  = {clrWin[N-2:0], clrPipe[1]};
      clrPipe = {clrPipe[0], BTN_CLR};
      clrPend = 1'b0;
      if (clrWin == {N{~clrLvl}}) begin clrLvl = ~clrLvl; clrPend = clrLvl; end
    end
    modelLive = 1;
  end

  // ---------------- per-cycle compare + command monitor ----------------
  int toggles = 0, resets = 0, lastToggleCyc = 0, errCyc = 0;
  bit errSeen = 0;
  always @(negedge CP) begin
    if (modelLive) begin
      chk("J", J, eJ);
      chk("K", K, eK);
      chk("RUNNING", RUNNING, eRun);
      chk("ERR", ERR, eErr);
      chk("DIGITS", DIGITS, toBcd(mCount));
      chk("WRAP", WRAP, eWrap);
      if (J === 1'b1 && K === 1'b1) begin toggles++; lastToggleCyc = cyc; end
      if (J === 1'b0 && K === 1'b1) resets++;
      if (ERR === 1'b1 && !errSeen) begin errSeen = 1; errCyc = cyc; end
      if (ERR !== 1'b1) errSeen = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic ss, input logic clr, input logic tk, input int n);
    BTN_SS = ss; BTN_CLR = clr; TICK = tk;
    repeat (n) @(negedge CP);
  endtask

  task automatic press(input logic ss, input logic clr);
    hold(ss, clr, 1'b0, N + 3);
    hold(1'b0, 1'b0, 1'b0, N + 8);
  endtask

  int tc, rc;

  initial begin
    // Reset and INIT sequence
    RST = 1'b1;
    hold(1'b0, 1'b0, 1'b0, 3);
    chk("rst_J", J, 1'b0);
    chk("rst_K", K, 1'b1);
    chk("rst_DIGITS", DIGITS, 16'h0000);
    RST = 1'b0;
    @(negedge CP);
    chk("init_J", J, 1'b0);
    chk("init_K", K, 1'b1);
    @(negedge CP);
    chk("init_hold", {J, K}, 2'b00);
    hold(1'b0, 1'b0, 1'b0, 3);
    chk("init_model_idle", mMode, M_IDLE);
    chk("init_ERR", ERR, 1'b0);

    // Start, 25 ticks, stop
    tc = toggles;
    press(1'b1, 1'b0);
    chk("start_RUNNING", RUNNING, 1'b1);
    chk("start_one_toggle", toggles - tc, 1);
    repeat (25) begin hold(1'b0, 1'b0, 1'b1, 1); hold(1'b0, 1'b0, 1'b0, 1); end
    chk("count25_DIGITS", DIGITS, 16'h0025);
    chk("count25_model", mCount, 25);
    press(1'b1, 1'b0);
    chk("stop_RUNNING", RUNNING, 1'b0);
    repeat (5) begin hold(1'b0, 1'b0, 1'b1, 1); hold(1'b0, 1'b0, 1'b0, 1); end
    chk("paused_DIGITS", DIGITS, 16'h0025);

    // Clear, then roll over 99.99
    press(1'b0, 1'b1);
    chk("clear_DIGITS", DIGITS, 16'h0000);
    press(1'b1, 1'b0);
    hold(1'b0, 1'b0, 1'b1, 9998);
    hold(1'b0, 1'b0, 1'b0, 1);
    chk("preload_DIGITS", DIGITS, 16'h9998);
    hold(1'b0, 1'b0, 1'b1, 1);
    chk("wrap1_DIGITS", DIGITS, 16'h9999);
    chk("wrap1_WRAP", WRAP, 1'b0);
    hold(1'b0, 1'b0, 1'b1, 1);
    chk("wrap2_DIGITS", DIGITS, 16'h0000);
    chk("wrap2_WRAP", WRAP, 1'b1);
    hold(1'b0, 1'b0, 1'b0, 1);
    chk("wrap3_WRAP", WRAP, 1'b0);

    // Simultaneous start/stop and clear while running at 0012
    hold(1'b0, 1'b0, 1'b1, 12);
    hold(1'b0, 1'b0, 1'b0, 1);
    chk("pre_both_DIGITS", DIGITS, 16'h0012);
    tc = toggles; rc = resets;
    press(1'b1, 1'b1);
    chk("both_DIGITS", DIGITS, 16'h0000);
    chk("both_RUNNING", RUNNING, 1'b0);
    chk("both_resets", resets - rc, 1);
    chk("both_no_toggle", toggles - tc, 0);
    chk("both_model_idle", mMode, M_IDLE);

    // Bounce in PAUSE at 0007
    press(1'b1, 1'b0);
    hold(1'b0, 1'b0, 1'b1, 7);
    press(1'b1, 1'b0);
    tc = toggles; rc = resets;
    repeat (5) begin hold(1'b1, 1'b0, 1'b0, N - 1); hold(1'b0, 1'b0, 1'b0, 2); end
    hold(1'b0, 1'b0, 1'b0, 10);
    chk("bounce_no_cmd", (toggles - tc) + (resets - rc), 0);
    chk("bounce_DIGITS", DIGITS, 16'h0007);

    // Randomized phase with occasional reset
    for (int i = 0; i < 150; i++) begin
      RST = ($urandom_range(0, 39) == 0);
      hold($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    RST = 1'b0;
    hold(1'b0, 1'b0, 1'b0, 20);

    // Stuck-at-0 flip-flop -> FAULT
    press(1'b0, 1'b1);
    stuck = 1'b1;
    press(1'b1, 1'b0);
    chk("fault_ERR", ERR, 1'b1);
    chk("fault_err_latency", errCyc - lastToggleCyc, 2);
    chk("fault_model", mMode, M_FAULT);
    tc = toggles; rc = resets;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("fault_no_cmd", (toggles - tc) + (resets - rc), 0);
    chk("fault_ERR_sticky", ERR, 1'b1);
    RST = 1'b1;
    hold(1'b0, 1'b0, 1'b0, 2);
    RST = 1'b0;
    stuck = 1'b0;
    hold(1'b0, 1'b0, 1'b0, 5);
    chk("rst_clears_ERR", ERR, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
